// File: rtl/uart_rx_core.sv
// uart_rx_core: UART serial receive engine.
// Start/data/stop framing, 5-8 data bits LSB first, no parity.
module uart_rx_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        serial_in,
  input  logic [3:0]  data_size,
  input  logic [13:0] bit_period,
  input  logic        data_read,
  output logic [7:0]  rx_data,
  output logic        data_ready,
  output logic        overrun_error,
  output logic        framing_error,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        hist;
  logic        synced;
  logic        fall;
  logic        sample;
  logic [13:0] timer;
  logic [13:0] period;
  logic [13:0] half;
  logic [3:0]  size;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        stop_bit;
  logic [3:0]  size_in;
  logic [13:0] period_in;

  assign synced = sync_q[SYNC_STAGES-1];
  assign fall   = hist & ~synced;
  assign half   = period >> 1;

  assign size_in = (data_size >= 4'd5 && data_size <= 4'd8)
                 ? data_size : 4'd8;
  assign period_in = (bit_period < 14'd4) ? 14'd4 : bit_period;

  assign rx_busy = (state != IDLE);

  // Line synchronizer plus one history flop for edge detect.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q <= '1;
      hist   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
      hist   <= synced;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and sample strobe.
  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) state_nx = START;
      end
      START: begin
        if (timer == half) begin
          sample   = 1'b1;
          state_nx = synced ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == period - 14'd1) begin
          sample = 1'b1;
          if (bit_cnt == size - 4'd1) state_nx = STOP;
        end
      end
      STOP: begin
        if (timer == period - 14'd1) begin
          sample   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Cycle timer, bit counter, config latch and shift register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer    <= '0;
      period   <= 14'd4;
      size     <= 4'd8;
      bit_cnt  <= '0;
      shreg    <= '0;
      stop_bit <= 1'b0;
    end else begin
      if (state == IDLE || sample || state_nx != state)
        timer <= '0;
      else
        timer <= timer + 14'd1;
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (fall) begin
          size   <= size_in;
          period <= period_in;
        end
      end
      if (state == DATA && sample) begin
        shreg   <= {synced, shreg[7:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == STOP && sample)
        stop_bit <= synced;
    end
  end

  // Output word and status flags; a LOAD beats a read.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
        framing_error <= 1'b0;
      end
      if (state == LOAD) begin
        if (stop_bit) begin
          rx_data       <= shreg >> (4'd8 - size);
          data_ready    <= 1'b1;
          framing_error <= 1'b0;
          if (data_ready && !data_read)
            overrun_error <= 1'b1;
          else
            overrun_error <= overrun_error;
        end else begin
          framing_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive engine for the UART peripheral. Converts an asynchronous serial line into parallel words and raises status flags. It sits directly upstream of the APB slave register block, which supplies its `data_size`/`bit_period` configuration and returns `data_read` when software reads the data buffer. Frame format: 1 start bit (0), 5–8 data bits sent LSB first, 1 stop bit (1), no parity.

## Interface
- `SYNC_STAGES`, default 2: number of flops in the `serial_in` synchronizer. Legal range is 2–3.
- `clk` in 1: system clock; all logic is on the rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `serial_in` in 1: asynchronous RX line; idles high.
- `data_size` in 4: data bits per frame. Values 5–8 are legal; any other value is treated as 8.
- `bit_period` in 14: clock cycles per bit. Values 0–3 are treated as 4.
- `data_read` in 1: one-cycle pulse; software has consumed `rx_data`.
- `rx_data` out 8: last good word, right-justified; unused upper bits are 0.
- `data_ready` out 1: `rx_data` holds an unread word.
- `overrun_error` out 1: a good frame arrived while `data_ready` was still 1.
- `framing_error` out 1: the most recent frame had stop bit = 0.
- `rx_busy` out 1: high in every state except IDLE.

## Operation
- **Synchronizer**: a `SYNC_STAGES` flop chain plus one history flop. All of these reset to 1.
- **Start detect**: in IDLE, a falling edge (history = 1, synced = 0) enters START.
- **Config capture**: on entry to START, `data_size` and `bit_period` are latched. Changes during a frame take effect on the next frame only.
- **State machine**: IDLE → START → DATA → STOP → LOAD → IDLE.
  - START: wait `half = eff_period >> 1` cycles, then sample. If the sample is 1, it is a false start: return to IDLE and touch no flags. If 0, go to DATA.
  - DATA: sample one bit every `eff_period` cycles. Shift in LSB first and count bits. After `eff_size` bits, go to STOP.
  - STOP: sample once, `eff_period` cycles after the last data sample. Go to LOAD.
  - LOAD: one cycle, during which outputs update. Then IDLE.
- **Counters**: 14-bit cycle timer, cleared on each state entry and on each sample. 4-bit bit counter.
- **LOAD with stop = 1 (good frame)**:
  - `rx_data` ← shifted word, zero-extended.
  - `data_ready` ← 1.
  - `framing_error` ← 0.
  - `overrun_error` ← 1 if `data_ready` was 1 and `data_read` is not asserted this cycle; otherwise unchanged.
- **LOAD with stop = 0 (bad frame)**: `framing_error` ← 1. `rx_data`, `data_ready` and `overrun_error` are unchanged.
- **`data_read` pulse**: clears `data_ready`, `overrun_error` and `framing_error` on the next edge.
- **Simultaneous `data_read` and good LOAD**: LOAD wins. `data_ready` stays 1, `overrun_error` is not set, and `framing_error` is 0.
- **Line held low after a frame**: no new start until a 1 is seen. An edge is required.

## Timing
- **Reset values**: `rx_data` = 0x00; `data_ready`, `overrun_error`, `framing_error` and `rx_busy` = 0; state = IDLE; shift register = 0.
- **Reset mid-frame**: immediate return to reset values; the partial frame is discarded.
- **Pin to edge detect**: `SYNC_STAGES` + 1 cycles.
- **Sample points**, counted from START entry at cycle 0:
  - start bit at cycle `half`;
  - data bit k (k = 0..n−1) at cycle `half + (k+1)·eff_period`;
  - stop bit at cycle `half + (n+1)·eff_period`;
  - LOAD in the following cycle, with flags visible one cycle after LOAD.
- **Back-to-back frames**: IDLE is re-entered right after LOAD. A new start edge seen in that cycle or later is accepted, so a minimum of a 1-bit gap is tolerated.
- **Output timing**: all outputs are registered, with no combinational path from input to output.

## Test plan
1. **Basic receive.** Reset, then `bit_period` = 10, `data_size` = 8, send 0xA5 with a good stop bit. Required: `rx_data` = 0xA5 and `data_ready` = 1, exactly `half` + 9·10 + 2 cycles after START entry; both error flags 0.
2. **5-bit frame.** `data_size` = 5, send bits 1,0,1,1,0 (LSB first). Required: `rx_data` = 0x0D. Then pulse `data_read`: `data_ready` = 0 the next cycle.
3. **Framing error.** Send 0x3C with stop = 0. Required: `framing_error` = 1; `data_ready` and `rx_data` keep their prior values. Then send a good 0x11: `framing_error` = 0 and `rx_data` = 0x11.
4. **Overrun and collision.**
   - Receive 0x55, leave it unread, receive 0xAA. Required: `rx_data` = 0xAA, `overrun_error` = 1.
   - Repeat with `data_read` asserted in the LOAD cycle. Required: `overrun_error` = 0 and `data_ready` = 1.
5. **False start and illegal config.** Glitch `serial_in` low for 2 cycles with `bit_period` = 20. Required: `rx_busy` returns to 0 and no flag changes. Then set `bit_period` = 2 and `data_size` = 12 and send 0xC3. Required: received as an 8-bit frame at a 4-cycle period, `rx_data` = 0xC3.
6. **Reset and config mid-frame.**
   - Assert `n_rst` mid-DATA. Required: all outputs are 0 immediately, and a following 0x81 frame is received correctly.
   - Change `bit_period` mid-frame. Required: the current frame still decodes at the old period.
